// File: rtl/cache.sv
// Direct-mapped cache tag/hit model.
// One byte address is looked up per clock against a tag store of
// 2**INDEX_W lines. A miss allocates the indexed line, and a hit bumps a
// saturating hit counter. Only tags and valid bits are kept; there is no
// data payload.
module cache #(
  parameter int ADDR_W   = 32,
  parameter int OFFSET_W = 4,
  parameter int INDEX_W  = 10,
  parameter int HIT_W    = 21
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] Data_in,
  output logic              Data_output,
  output logic [HIT_W-1:0]  hits
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;

  logic [INDEX_W-1:0] index;
  logic [TAG_W-1:0]   tag;
  logic               hit;
  logic               hits_max;

  // One valid bit per line; cleared as a group by reset.
  logic [LINES-1:0]   valid;
  // Tag store; contents only matter when the matching valid bit is set.
  logic [TAG_W-1:0]   tag_mem [LINES];

  // The byte offset within a line never affects the lookup.
  logic unused_offset;
  assign unused_offset = &{1'b0, Data_in[OFFSET_W-1:0]};

  assign index = Data_in[OFFSET_W+INDEX_W-1:OFFSET_W];
  assign tag   = Data_in[ADDR_W-1:OFFSET_W+INDEX_W];

  // Tag compare for the access sampled at the next edge.
  always_comb begin
    hit      = valid[index] && (tag_mem[index] == tag);
    hits_max = &hits;
  end

  // Valid bits, registered hit flag and the saturating hit counter.
  // NOTE: all sequential state uses non-blocking (<=) assignments, so every
  // register sees the pre-edge values. A lookup therefore observes the
  // allocation made on the previous cycle and never the one made on this
  // cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid       <= '0;
      Data_output <= 1'b0;
      hits        <= '0;
    end else begin
      Data_output <= hit;
      if (hit) begin
        if (!hits_max) hits <= hits + 1'b1;
      end else begin
        valid[index] <= 1'b1;
      end
    end
  end

  // Tag allocation on a miss.
  // NOTE: the tag array is deliberately left out of reset. Clearing the
  // valid bits is enough to invalidate every line, and a resettable
  // 1024-entry array could not be mapped onto a RAM.
  always_ff @(posedge clk) begin
    if (!hit) tag_mem[index] <= tag;
  end

endmodule

// File: tb/tb_cache.sv
// Self-checking bench for the direct-mapped cache.
// Expected results come from a behavioural reference model. They are pushed
// to a scoreboard queue when an access is driven, and popped one cycle later
// to be compared against the DUT. A second instance with a 4-bit counter
// exercises the saturation behaviour within a short run.
module tb_cache;

  typedef struct packed {
    logic        hit;
    logic [31:0] hits;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] data_in;
  logic        data_output;
  logic [20:0] hits;

  logic        rst_s_n;
  logic [31:0] data_in_s;
  logic        data_output_s;
  logic [3:0]  hits_s;

  int n_checks = 0;
  int n_fails  = 0;

  exp_t sb[$];

  // Reference model state.
  bit          m_valid [1024];
  logic [17:0] m_tag   [1024];
  int          m_hits;

  cache dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .Data_in    (data_in),
    .Data_output(data_output),
    .hits       (hits)
  );

  cache #(.HIT_W(4)) dut_s (
    .clk        (clk),
    .rst_n      (rst_s_n),
    .Data_in    (data_in_s),
    .Data_output(data_output_s),
    .hits       (hits_s)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 1024; i++) m_valid[i] = 1'b0;
    m_hits = 0;
    sb.delete();
  endtask

  // Drive one access, then compare the DUT output after the sampling edge.
  task automatic access(input logic [31:0] addr, input string tag);
    exp_t e;
    exp_t got;
    int   idx;
    idx   = int'(addr[13:4]);
    e.hit = m_valid[idx] && (m_tag[idx] == addr[31:14]);
    if (e.hit) begin
      if (m_hits < 2097151) m_hits++;
    end else begin
      m_valid[idx] = 1'b1;
      m_tag[idx]   = addr[31:14];
    end
    e.hits = 32'(m_hits);
    sb.push_back(e);
    data_in = addr;
    @(posedge clk);
    #1;
    got = sb.pop_front();
    check({tag, "_hit"},  {31'b0, data_output}, {31'b0, got.hit});
    check({tag, "_hits"}, {11'b0, hits},        got.hits);
  endtask

  initial begin
    logic [20:0] hits_before;
    int          sat_exp;

    rst_n     = 1'b0;
    rst_s_n   = 1'b0;
    data_in   = '0;
    data_in_s = '0;
    model_reset();
    #2;
    check("reset_out",  {31'b0, data_output}, 32'd0);
    check("reset_hits", {11'b0, hits},        32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // A repeated address: miss, then hit.
    access(32'h0000_0000, "first_miss");
    access(32'h0000_0000, "repeat_hit");
    check("repeat_hits_one", {11'b0, hits}, 32'd1);

    // Two addresses within the same 16-byte line.
    access(32'h0000_0010, "line1_miss");
    access(32'h0000_001C, "line1_same_line_hit");

    // Conflict eviction at index 0: every access misses.
    access(32'h0000_8000, "evict_setup");
    hits_before = hits;
    access(32'h0000_0000, "conflict_a");
    access(32'h0000_4000, "conflict_b");
    access(32'h0000_0000, "conflict_c");
    check("conflict_out",  {31'b0, data_output}, 32'd0);
    check("conflict_hits", {11'b0, hits}, {11'b0, hits_before});

    // Fresh reset, then fill all 1024 lines and replay them.
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 1024; i++) access(32'(i * 16), "fill");
    check("fill_hits_zero", {11'b0, hits}, 32'd0);
    for (int i = 0; i < 1024; i++) access(32'(i * 16), "replay");
    check("replay_hits_1024", {11'b0, hits}, 32'd1024);

    // Twenty more hits, then an asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 20; i++) access(32'(i * 16 + 4), "pre_reset_hit");
    check("pre_reset_out", {31'b0, data_output}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_reset_out",  {31'b0, data_output}, 32'd0);
    check("async_reset_hits", {11'b0, hits},        32'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    access(32'h0000_0000, "post_reset_miss");
    check("post_reset_out", {31'b0, data_output}, 32'd0);
    access(32'h0000_0010, "post_reset_miss2");
    access(32'h0000_0000, "post_reset_rehit");

    // Saturation on the 4-bit instance: one miss, then 18 hits.
    @(negedge clk);
    rst_s_n   = 1'b1;
    data_in_s = 32'h0000_1230;
    @(posedge clk);
    #1;
    check("sat_first_miss", {31'b0, data_output_s}, 32'd0);
    sat_exp = 0;
    for (int i = 0; i < 18; i++) begin
      @(posedge clk);
      #1;
      if (sat_exp < 15) sat_exp++;
      check("sat_hit_flag", {31'b0, data_output_s}, 32'd1);
      check("sat_count",    {28'b0, hits_s},        32'(sat_exp));
    end
    check("sat_hold_max", {28'b0, hits_s}, 32'd15);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
